mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter sharing the single-port synchronous instruction/data memory between the CPU instruction-fetch unit and the load/store unit. Grants one access per cycle, drives the memory's rw/addr/din pins, and routes the 1-cycle-latency read data back to the requester that issued the read. Sits between the CPU core and the memory; the core sees two independent request/grant/read-valid ports.

## Interface
- AW, 9, address width (matches memory addr port)
- DW, 16, data width
- STARVE_MAX, 4, consecutive contended cycles the fetch port may lose before forced grant (used only with MEM_ARB_STARVE_EN)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- if_req  in  1  fetch read request; held with stable if_addr until if_gnt
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch access issued this cycle
- if_rvalid  out  1  fetch read data valid this cycle
- if_rdata  out  DW  fetch read data
- d_req  in  1  data request; held with stable d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_gnt  out  1  data access issued this cycle
- d_rvalid  out  1  data read data valid this cycle
- d_rdata  out  DW  data read data
- mem_rw  out  1  memory rw (0 read, 1 write)
- mem_addr  out  AW  memory address
- mem_din  out  DW  memory write data
- mem_dout  in  DW  memory registered read data

## Operation
- Grant decision combinational from current requests and registered state; at most one of if_gnt/d_gnt high per cycle.
- Default priority: d_req wins over if_req when both high.
- Granted port's address/data/we drive mem_addr/mem_din/mem_rw in the same cycle; fetch always drives mem_rw=0.
- No request: mem_rw=0, mem_addr=0, mem_din=0 (harmless read, no rvalid produced).
- Read tracking registers: rd_pend (1 bit), rd_owner (0 fetch, 1 data). Set on any granted read, cleared otherwise each cycle.
- Cycle after a granted read: owner's rvalid=1, rdata=mem_dout. Non-owner rdata=0, rvalid=0. Writes produce no rvalid.
- Fully pipelined: new grant allowed in the same cycle a previous read's data returns; back-to-back reads give rvalid every cycle.
- Requester keeping req high after gnt is a new request; one gnt pulse per access.
- Write then read same address on consecutive cycles returns the new data (memory write completes at the write-grant edge).

## Timing
- Reset (rst_n low at posedge): rd_pend=0, rd_owner=0, starve count=0. During and immediately after reset cycle: if_rvalid=d_rvalid=0, if_rdata=d_rdata=0; gnt outputs still follow requests combinationally only once rst_n is high (while rst_n low: all gnt=0, mem_rw=0, mem_addr=0, mem_din=0).
- Reset asserted the cycle after a granted read: pending read discarded, no rvalid.
- Read latency: gnt in cycle N -> rvalid in N+1.
- Write: committed at end of grant cycle; d_gnt is the only acknowledgment.
- Memory contents are not reset by this block.

## Configuration
- MEM_ARB_STARVE_EN defined: counter (width clog2(STARVE_MAX+1), saturating) increments each cycle if_req=1 and d_gnt=1; clears on if_gnt or if_req=0. When count==STARVE_MAX, fetch wins the next contended cycle, then count clears.
- Undefined: strict data-over-fetch priority; fetch may starve indefinitely under continuous d_req; no counter logic.

## Test plan
- Fetch only: if_req=1, if_addr=5 for one cycle -> if_gnt=1, mem_addr=5, mem_rw=0; next cycle if_rvalid=1, if_rdata=mem[5].
- Write/read data: d_we=1, d_addr=30, d_wdata=16'hBEEF, then d_we=0, d_addr=30 -> two d_gnt pulses, second yields d_rvalid=1, d_rdata=16'hBEEF one cycle later; if_rvalid stays 0.
- Contention: if_req and d_req both high 3 cycles, d reads -> d_gnt 3 consecutive cycles, if_gnt on cycle 4, rvalids routed to correct ports each cycle after grant.
- Starvation (MEM_ARB_STARVE_EN, STARVE_MAX=4): both requests held continuously -> d_gnt 4 cycles, if_gnt on 5th, pattern repeats; without macro if_gnt never asserts.
- Reset mid-read: grant fetch read at addr 2, assert rst_n=0 next cycle -> if_rvalid=0, all outputs zero; after release, new read of addr 2 returns mem[2] one cycle after grant.
- Idle: no requests 10 cycles -> mem_rw=0, mem_addr=0, all gnt/rvalid 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared single-port instruction/data memory: data port over fetch,
// 1-cycle read-data routing. Define MEM_ARB_STARVE_EN to bound fetch starvation at STARVE_MAX.
module mem_arbiter #(
    parameter int AW         = 9,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    logic rd_pend;
    logic rd_owner;
    logic force_if;

`ifdef MEM_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;

    assign force_if = (starve_cnt == CNT_W'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (if_gnt || !if_req) begin
            starve_cnt <= '0;
        end else if (d_gnt && (starve_cnt != CNT_W'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end
`else
    // Constant false: strict data-over-fetch priority.
    assign force_if = (STARVE_MAX < 0);
`endif

    // Stage 0: combinational grant and memory pin drive.
    always_comb begin
        if_gnt   = 1'b0;
        d_gnt    = 1'b0;
        mem_rw   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (rst_n) begin
            if (d_req && !(force_if && if_req)) begin
                d_gnt    = 1'b1;
                mem_rw   = d_we;
                mem_addr = d_addr;
                mem_din  = d_wdata;
            end else if (if_req) begin
                if_gnt   = 1'b1;
                mem_addr = if_addr;
            end
        end
    end

    // Stage 1: track the read issued last cycle so its data reaches the right port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            rd_pend  <= if_gnt || (d_gnt && !d_we);
            rd_owner <= d_gnt && !d_we;
        end
    end

    // Gating with rst_n discards a read whose data would return during reset.
    assign if_rvalid = rst_n && rd_pend && !rd_owner;
    assign d_rvalid  = rst_n && rd_pend && rd_owner;
    assign if_rdata  = if_rvalid ? mem_dout : '0;
    assign d_rdata   = d_rvalid ? mem_dout : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus hand sequences, with a read-data
// scoreboard fed from a bench-side shadow of the memory contents.
module tb_mem_arbiter;

    localparam int AW = 9;
    localparam int DW = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    function automatic logic [DW-1:0] pat(input int i);
        return DW'(i * 257) ^ 16'h5A5A;
    endfunction

    // Synchronous single-port memory, registered read, loaded on the first edge.
    logic [DW-1:0] mem [DEPTH];
    logic          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= pat(i);
            mem_init <= 1'b1;
            mem_dout <= '0;
        end else begin
            if (mem_rw) mem[mem_addr] <= mem_din;
            mem_dout <= mem[mem_addr];
        end
    end

    typedef struct {
        logic          if_req;
        logic [AW-1:0] if_addr;
        logic          d_req;
        logic          d_we;
        logic [AW-1:0] d_addr;
        logic [DW-1:0] d_wdata;
        logic          e_ig;
        logic          e_dg;
    } vec_t;

    typedef struct {
        logic          vld;
        logic          owner;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            errors = 0;
    int            checks = 0;

    function automatic vec_t mk(input logic ir, input int ia, input logic dr, input logic dw,
                                input int da, input int wd, input logic ig, input logic dg);
        vec_t v;
        v.if_req = ir; v.if_addr = AW'(ia);
        v.d_req = dr; v.d_we = dw; v.d_addr = AW'(da); v.d_wdata = DW'(wd);
        v.e_ig = ig; v.e_dg = dg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // One clock: drive, check read return of the previous grant, check this cycle's grant.
    task automatic run_cycle(input logic rn, input vec_t v, input string tag);
        exp_t e, n;
        logic ev;
        logic [DW-1:0] ed;
        rst_n = rn; if_req = v.if_req; if_addr = v.if_addr;
        d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
        @(negedge clk);
        if (sb.size() == 0) begin
            chk({tag, " scoreboard_empty"}, 32'd1, 32'd0);
            e.vld = 1'b0; e.owner = 1'b0; e.data = '0;
        end else begin
            e = sb.pop_front();
        end
        ev = e.vld && rn;
        ed = e.data;
        chk({tag, " if_rvalid"}, 32'(if_rvalid), 32'(ev && !e.owner));
        chk({tag, " d_rvalid"},  32'(d_rvalid),  32'(ev && e.owner));
        chk({tag, " if_rdata"},  32'(if_rdata),  (ev && !e.owner) ? 32'(ed) : 32'd0);
        chk({tag, " d_rdata"},   32'(d_rdata),   (ev && e.owner) ? 32'(ed) : 32'd0);
        chk({tag, " if_gnt"},    32'(if_gnt),    32'(v.e_ig));
        chk({tag, " d_gnt"},     32'(d_gnt),     32'(v.e_dg));
        chk({tag, " mem_rw"},    32'(mem_rw),    32'(v.e_dg && v.d_we));
        chk({tag, " mem_addr"},  32'(mem_addr),
            v.e_dg ? 32'(v.d_addr) : (v.e_ig ? 32'(v.if_addr) : 32'd0));
        chk({tag, " mem_din"},   32'(mem_din),   v.e_dg ? 32'(v.d_wdata) : 32'd0);
        n.vld = 1'b0; n.owner = 1'b0; n.data = '0;
        if (v.e_ig) begin
            n.vld = 1'b1; n.data = ref_mem[v.if_addr];
        end else if (v.e_dg && !v.d_we) begin
            n.vld = 1'b1; n.owner = 1'b1; n.data = ref_mem[v.d_addr];
        end else if (v.e_dg && v.d_we) begin
            ref_mem[v.d_addr] = v.d_wdata;
        end
        sb.push_back(n);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[15];
    vec_t idle;

    initial begin
        exp_t z;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);
        z.vld = 1'b0; z.owner = 1'b0; z.data = '0;
        sb.push_back(z);
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0);

        //         if_req addr d_req we  addr  wdata     ig dg
        tbl[0]  = mk(0,   0,   0,    0,  0,    0,        0, 0);
        tbl[1]  = mk(1,   5,   0,    0,  0,    0,        1, 0);
        tbl[2]  = mk(0,   0,   0,    0,  0,    0,        0, 0);
        tbl[3]  = mk(0,   0,   1,    1,  30,   'hBEEF,   0, 1);
        tbl[4]  = mk(0,   0,   1,    0,  30,   0,        0, 1);
        tbl[5]  = mk(0,   0,   0,    0,  0,    0,        0, 0);
        tbl[6]  = mk(1,   7,   1,    0,  40,   'h1111,   0, 1);
        tbl[7]  = mk(1,   7,   1,    0,  41,   0,        0, 1);
        tbl[8]  = mk(1,   7,   1,    0,  42,   0,        0, 1);
        tbl[9]  = mk(1,   7,   0,    0,  0,    0,        1, 0);
        tbl[10] = mk(1,   8,   1,    1,  511,  'h7FFF,   0, 1);
        tbl[11] = mk(0,   0,   1,    0,  511,  0,        0, 1);
        tbl[12] = mk(1,   511, 0,    0,  0,    0,        1, 0);
        tbl[13] = mk(1,   30,  0,    0,  0,    0,        1, 0);
        tbl[14] = mk(0,   0,   0,    0,  0,    0,        0, 0);

        #1;
        // Reset with both requests high: nothing granted, pins quiet.
        run_cycle(0, mk(1, 3, 1, 1, 9, 'h1234, 0, 0), "reset0");
        run_cycle(0, mk(1, 3, 1, 0, 9, 0, 0, 0), "reset1");
        run_cycle(1, idle, "post_reset");

        for (int i = 0; i < 15; i++) run_cycle(1, tbl[i], $sformatf("vec%0d", i));

        for (int k = 0; k < 10; k++) run_cycle(1, idle, $sformatf("idle%0d", k));

        // Both ports held continuously.
        for (int k = 1; k <= 10; k++) begin
            logic ig;
`ifdef MEM_ARB_STARVE_EN
            ig = ((k % 5) == 0);
`else
            ig = 1'b0;
`endif
            run_cycle(1, mk(1, 200, 1, 0, 100 + k, 0, ig, !ig), $sformatf("starve%0d", k));
        end
        run_cycle(1, idle, "starve_end");
        run_cycle(1, idle, "starve_gap");

        // Reset right after a fetch read grant discards the return.
        run_cycle(1, mk(1, 2, 0, 0, 0, 0, 1, 0), "rst_grant");
        run_cycle(0, mk(1, 2, 1, 0, 3, 0, 0, 0), "rst_mid0");
        run_cycle(0, idle, "rst_mid1");
        run_cycle(1, idle, "rst_release");
        run_cycle(1, mk(1, 2, 0, 0, 0, 0, 1, 0), "rst_reread");
        run_cycle(1, idle, "rst_reread_data");

        // Write then immediately read back through the data port, fetch interleaved.
        run_cycle(1, mk(0, 0, 1, 1, 2, 'hCAFE, 0, 1), "wr2");
        run_cycle(1, mk(0, 0, 1, 0, 2, 0, 0, 1), "rd2");
        run_cycle(1, mk(1, 2, 0, 0, 0, 0, 1, 0), "if_rd2");
        run_cycle(1, idle, "final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
